// File: rtl/i2s_pkg.sv
// i2s_pkg: framing constants and parameter legality checks shared by the I2S transmitter and receiver.
package i2s_pkg;
  localparam logic [7:0] CLK_DIVISION_DEF    = 8'd14;
  localparam logic [7:0] AUDIO_WORD_LEN_DEF  = 8'd24;
  localparam logic [7:0] AUDIO_FRAME_LEN_DEF = 8'd64;

  function automatic logic [7:0] bclk_half(input logic [7:0] div);
    return (div >> 1) - 8'd1;
  endfunction

  function automatic logic [7:0] frame_half(input logic [7:0] len);
    return len >> 1;
  endfunction

  // Each channel slot must hold the delay bit plus the whole word.
  function automatic logic params_ok(input logic [7:0] div, input logic [7:0] word,
                                     input logic [7:0] frame);
    return !div[0] && div >= 8'd4 && word >= 8'd2 && !frame[0] &&
           {1'b0, frame >> 1} >= {1'b0, word} + 9'd1;
  endfunction
endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: BCLK/LRCLK generation and frame bit counter; fe_o marks the BCLK falling-edge cycle.
module i2s_clk_gen import i2s_pkg::*; #(
  parameter logic [7:0] CLK_DIVISION    = CLK_DIVISION_DEF,
  parameter logic [7:0] AUDIO_FRAME_LEN = AUDIO_FRAME_LEN_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  output logic       bclk_o,
  output logic       lrclk_o,
  output logic       fe_o,
  output logic [7:0] nxt_idx_o
);
  localparam logic [7:0] HALF  = bclk_half(CLK_DIVISION);
  localparam logic [7:0] FHALF = frame_half(AUDIO_FRAME_LEN);

  logic [7:0] div_q, idx_q;
  logic       bclk_q, lr_q, tick;

  assign tick      = enable_i && div_q == 8'd0;
  assign fe_o      = tick && bclk_q;
  assign nxt_idx_o = (idx_q == AUDIO_FRAME_LEN - 8'd1) ? 8'd0 : idx_q + 8'd1;
  assign bclk_o    = bclk_q;
  assign lrclk_o   = lr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= HALF;
      bclk_q <= 1'b0;
      lr_q   <= 1'b1;
      idx_q  <= AUDIO_FRAME_LEN - 8'd1;
    end else if (enable_i) begin
      div_q <= tick ? HALF : div_q - 8'd1;
      if (tick) bclk_q <= ~bclk_q;
      if (fe_o) begin
        idx_q <= nxt_idx_o;
        lr_q  <= nxt_idx_o >= FHALF;
      end
    end
  end
endmodule

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: I2S master transmitter with a one-entry stereo holding register.
module i2s_transmitter import i2s_pkg::*; #(
  parameter logic [7:0] CLK_DIVISION    = CLK_DIVISION_DEF,
  parameter logic [7:0] AUDIO_WORD_LEN  = AUDIO_WORD_LEN_DEF,
  parameter logic [7:0] AUDIO_FRAME_LEN = AUDIO_FRAME_LEN_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic [AUDIO_WORD_LEN-1:0] left_data_i,
  input  logic [AUDIO_WORD_LEN-1:0] right_data_i,
  input  logic                      sample_valid_i,
  output logic                      sample_ready_o,
  output logic                      bclk_o,
  output logic                      lrclk_o,
  output logic                      audio_data_o,
  output logic                      frame_start_o,
  output logic                      underrun_o
);
  localparam logic [7:0] FHALF = frame_half(AUDIO_FRAME_LEN);

  if (!params_ok(CLK_DIVISION, AUDIO_WORD_LEN, AUDIO_FRAME_LEN)) begin : g_bad_params
    $error("i2s_transmitter: illegal CLK_DIVISION/AUDIO_WORD_LEN/AUDIO_FRAME_LEN");
  end

  logic [AUDIO_WORD_LEN-1:0] hold_l_q, hold_r_q, shift_l_q, shift_r_q, sel_w;
  logic [7:0] nxt_idx, h, off;
  logic fe, chan, load, accept, bit_d, ready_d;
  logic ready_q, data_q, fs_q, ur_q;

  i2s_clk_gen #(.CLK_DIVISION(CLK_DIVISION), .AUDIO_FRAME_LEN(AUDIO_FRAME_LEN)) u_clk_gen (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .bclk_o(bclk_o),
    .lrclk_o(lrclk_o), .fe_o(fe), .nxt_idx_o(nxt_idx)
  );

  // Slot h carries word bit AUDIO_WORD_LEN-h; h==0 is the I2S delay bit.
  always_comb begin
    chan    = nxt_idx >= FHALF;
    h       = chan ? nxt_idx - FHALF : nxt_idx;
    off     = AUDIO_WORD_LEN - h;
    sel_w   = (chan ? shift_r_q : shift_l_q) >> off;
    bit_d   = h != 8'd0 && h <= AUDIO_WORD_LEN && sel_w[0];
    load    = fe && nxt_idx == 8'd0;
    accept  = sample_valid_i && ready_q;
    ready_d = accept ? 1'b0 : (load ? 1'b1 : ready_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      shift_l_q <= '0;
      shift_r_q <= '0;
      ready_q   <= 1'b1;
      data_q    <= 1'b0;
      fs_q      <= 1'b0;
      ur_q      <= 1'b0;
    end else begin
      if (accept) begin
        hold_l_q <= left_data_i;
        hold_r_q <= right_data_i;
      end
      if (load) begin
        shift_l_q <= ready_q ? '0 : hold_l_q;
        shift_r_q <= ready_q ? '0 : hold_r_q;
      end
      if (fe) data_q <= bit_d;
      ready_q <= ready_d;
      fs_q    <= load;
      ur_q    <= load && ready_q;
    end
  end

  assign sample_ready_o = ready_q;
  assign audio_data_o   = data_q;
  assign frame_start_o  = fs_q;
  assign underrun_o     = ur_q;
endmodule

// File: tb/tb_i2s_transmitter.sv
// tb_i2s_transmitter: directed checks of I2S framing, handshake, freeze and reset behaviour.
module tb_i2s_transmitter;
  logic clk_i = 1'b0, rst_ni = 1'b0, enable_i = 1'b0, sample_valid_i = 1'b0;
  logic [23:0] left_data_i = '0, right_data_i = '0;
  logic sample_ready_o, bclk_o, lrclk_o, audio_data_o, frame_start_o, underrun_o;
  int n_vec = 0, n_err = 0;

  always #5 clk_i = ~clk_i;

  i2s_transmitter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .left_data_i(left_data_i),
    .right_data_i(right_data_i), .sample_valid_i(sample_valid_i),
    .sample_ready_o(sample_ready_o), .bclk_o(bclk_o), .lrclk_o(lrclk_o),
    .audio_data_o(audio_data_o), .frame_start_o(frame_start_o), .underrun_o(underrun_o)
  );

  // Received slots as {lrclk, 32 slot bits MSB-first}, framed by LRCLK transitions.
  logic [32:0] cap[$];
  logic [31:0] sh = '0;
  logic prev_lr = 1'b1;
  int pos = 99;

  always @(posedge bclk_o) begin
    if (lrclk_o != prev_lr) pos = 0;
    else pos = pos + 1;
    prev_lr = lrclk_o;
    sh = {sh[30:0], audio_data_o};
    if (pos == 31) cap.push_back({lrclk_o, sh});
  end

  function automatic logic [32:0] slot(input logic lr, input logic [23:0] w);
    return {lr, 1'b0, w, 7'b0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_bclk"}, bclk_o, 1'b0);
    chk({p, "_lrclk"}, lrclk_o, 1'b1);
    chk({p, "_data"}, audio_data_o, 1'b0);
    chk({p, "_ready"}, sample_ready_o, 1'b1);
    chk({p, "_fs"}, frame_start_o, 1'b0);
    chk({p, "_ur"}, underrun_o, 1'b0);
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!frame_start_o && n < 2000);
    chk("fs_seen", frame_start_o, 1'b1);
  endtask

  task automatic wait_cap(input int k);
    int n = 0;
    while (cap.size() < k && n < 3000) begin
      tick(1);
      n++;
    end
    chk("cap_count", cap.size() >= k, 1'b1);
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    left_data_i = l;
    right_data_i = r;
    sample_valid_i = 1'b1;
    tick(1);
    sample_valid_i = 1'b0;
    chk("ready_after_accept", sample_ready_o, 1'b0);
  endtask

  initial begin
    int n, acc, rdy_hi, fs_cnt, ur_cnt, diffs;
    logic rdy;
    logic [3:0] snap;
    #12;
    chk_reset("rst");
    rst_ni = 1'b1;
    tick(2);
    chk_reset("idle");
    // 1: clock generation and first frame wrap
    enable_i = 1'b1;
    tick(6);
    chk("bclk_pre_rise", bclk_o, 1'b0);
    tick(1);
    chk("bclk_rise", bclk_o, 1'b1);
    tick(6);
    chk("lr_pre_wrap", lrclk_o, 1'b1);
    chk("fs_pre_wrap", frame_start_o, 1'b0);
    tick(1);
    chk("bclk_fall", bclk_o, 1'b0);
    chk("lr_wrap", lrclk_o, 1'b0);
    chk("fs_wrap", frame_start_o, 1'b1);
    chk("ur_wrap", underrun_o, 1'b1);
    tick(1);
    chk("fs_pulse", frame_start_o, 1'b0);
    chk("ur_pulse", underrun_o, 1'b0);
    tick(446);
    chk("lr_pre_half", lrclk_o, 1'b0);
    tick(1);
    chk("lr_half", lrclk_o, 1'b1);
    wait_fs(n);
    chk("lr_period", 64'(n + 448), 64'd896);
    // 2: single pair A5/5A
    push(24'hA5A5A5, 24'h5A5A5A);
    wait_fs(n);
    chk("fs_interval", 64'(n + 1), 64'd896);
    chk("ur_queued", underrun_o, 1'b0);
    chk("ready_after_load", sample_ready_o, 1'b1);
    cap.delete();
    wait_cap(2);
    chk("t2_left", cap[0], slot(1'b0, 24'hA5A5A5));
    chk("t2_right", cap[1], slot(1'b1, 24'h5A5A5A));
    // 3: continuous valid with incrementing data
    wait_fs(n);
    cap.delete();
    acc = 0; rdy_hi = 0; fs_cnt = 0; ur_cnt = 0; n = 0;
    left_data_i = 24'h100000;
    right_data_i = 24'h200000;
    sample_valid_i = 1'b1;
    while (fs_cnt < 4 && n < 5000) begin
      rdy = sample_ready_o;
      tick(1);
      n++;
      if (rdy) begin
        acc++;
        rdy_hi++;
        left_data_i = 24'h100000 + 24'(acc);
        right_data_i = 24'h200000 + 24'(acc);
      end
      if (frame_start_o) fs_cnt++;
      if (underrun_o) ur_cnt++;
    end
    sample_valid_i = 1'b0;
    chk("t3_frames", fs_cnt, 4);
    chk("t3_accepts", acc, 4);
    chk("t3_ready_cycles", rdy_hi, 4);
    chk("t3_underruns", ur_cnt, 0);
    chk("t3_cap_count", cap.size(), 8);
    chk("t3_zero_l", cap[0], slot(1'b0, 24'h0));
    chk("t3_zero_r", cap[1], slot(1'b1, 24'h0));
    for (int k = 0; k < 3; k++) begin
      chk("t3_left", cap[2 + 2 * k], slot(1'b0, 24'h100000 + 24'(k)));
      chk("t3_right", cap[3 + 2 * k], slot(1'b1, 24'h200000 + 24'(k)));
    end
    // 4: valid in the frame-load cycle with empty holding register
    tick(895);
    left_data_i = 24'hC0FFEE;
    right_data_i = 24'h123456;
    sample_valid_i = 1'b1;
    tick(1);
    sample_valid_i = 1'b0;
    chk("t4_fs", frame_start_o, 1'b1);
    chk("t4_ur", underrun_o, 1'b1);
    chk("t4_ready", sample_ready_o, 1'b0);
    cap.delete();
    wait_fs(n);
    chk("t4_next_ur", underrun_o, 1'b0);
    wait_cap(4);
    chk("t4_zero_l", cap[0], slot(1'b0, 24'h0));
    chk("t4_zero_r", cap[1], slot(1'b1, 24'h0));
    chk("t4_left", cap[2], slot(1'b0, 24'hC0FFEE));
    chk("t4_right", cap[3], slot(1'b1, 24'h123456));
    // 5: enable dropped mid-left-word
    push(24'h89ABCD, 24'h765432);
    wait_fs(n);
    cap.delete();
    tick(200);
    snap = {bclk_o, lrclk_o, audio_data_o, sample_ready_o};
    enable_i = 1'b0;
    diffs = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if ({bclk_o, lrclk_o, audio_data_o, sample_ready_o} != snap || frame_start_o || underrun_o)
        diffs++;
    end
    chk("t5_frozen", diffs, 0);
    enable_i = 1'b1;
    wait_cap(2);
    chk("t5_left", cap[0], slot(1'b0, 24'h89ABCD));
    chk("t5_right", cap[1], slot(1'b1, 24'h765432));
    // 6: reset mid-frame with a pending sample
    wait_fs(n);
    tick(100);
    push(24'hDEAD01, 24'hBEEF02);
    #2 rst_ni = 1'b0;
    #1;
    chk_reset("midrst");
    tick(2);
    rst_ni = 1'b1;
    wait_fs(n);
    chk("t6_first_fs", n, 14);
    chk("t6_ur", underrun_o, 1'b1);
    chk("t6_ready", sample_ready_o, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
